// File: rtl/calc_seq_pkg.sv
// calc_sequencer shared definitions: op codes, register offsets
// for the CPU side and the math units, and FSM state encoding.
package calc_seq_pkg;

    typedef enum logic [1:0] {
        OP_MULT = 2'd0,
        OP_DIV  = 2'd1,
        OP_SQRT = 2'd2
    } op_t;

    // CPU-visible register offsets
    localparam logic [4:0] CTRL   = 5'h00;
    localparam logic [4:0] A      = 5'h04;
    localparam logic [4:0] B      = 5'h08;
    localparam logic [4:0] RESULT = 5'h10;
    localparam logic [4:0] STATUS = 5'h14;

    // Register offsets common to every math unit
    localparam logic [4:0] U_A    = 5'h04;
    localparam logic [4:0] U_B    = 5'h08;
    localparam logic [4:0] U_INIT = 5'h0C;
    localparam logic [4:0] U_RES  = 5'h10;
    localparam logic [4:0] U_DONE = 5'h14;

    typedef logic [3:0] state_t;

    localparam state_t IDLE     = 4'd0;
    localparam state_t WR_A     = 4'd1;
    localparam state_t WR_B     = 4'd2;
    localparam state_t INIT     = 4'd3;
    localparam state_t INIT_CLR = 4'd4;
    localparam state_t POLL     = 4'd5;
    localparam state_t CHECK    = 4'd6;
    localparam state_t RD_RES   = 4'd7;
    localparam state_t CAPT     = 4'd8;

    function automatic logic [2:0] op_onehot(op_t op);
        return 3'b001 << op;
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// CPU peripheral bus as seen by calc_sequencer: the CPU is the
// master, the sequencer is the slave returning registered read data.
interface calc_sequencer_if;

    logic [31:0] d_in;
    logic        cs;
    logic [4:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] d_out;

    modport master (
        output d_in, cs, addr, rd, wr,
        input  d_out
    );

    modport slave (
        input  d_in, cs, addr, rd, wr,
        output d_out
    );

endinterface

// File: rtl/calc_sequencer.sv
// Runs one mult/div/sqrt job on the shared math units: writes the
// operands, pulses init, polls done with a timeout, fetches result.
module calc_sequencer
    import calc_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic             clk,
    input  logic             reset,
    calc_sequencer_if.slave  bus,
    output logic [2:0]       m_cs,
    output logic [4:0]       m_addr,
    output logic             m_rd,
    output logic             m_wr,
    output logic [15:0]      m_d_in,
    input  logic [31:0]      mult_dout,
    input  logic [31:0]      div_dout,
    input  logic [31:0]      sqrt_dout
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    op_t              op;
    logic [15:0]      op_a;
    logic [15:0]      op_b;
    logic [31:0]      res_q;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      sel_dout;
    logic             cpu_wr;
    logic             cpu_rd;
    logic             unused_bits;

    assign cpu_wr = bus.cs & bus.wr;
    assign cpu_rd = bus.cs & bus.rd;

    // Operands are only 16 bits wide; the upper write-data bits are dropped.
    assign unused_bits = ^bus.d_in[31:16];

    // Route the read data of the unit owning the current job.
    always_comb begin
        sel_dout = '0;
        case (op)
            OP_MULT: sel_dout = mult_dout;
            OP_DIV:  sel_dout = div_dout;
            OP_SQRT: sel_dout = sqrt_dout;
            default: sel_dout = '0;
        endcase
    end

    // Master strobes decode straight from the state so each state
    // drives exactly its own unit access in its own cycle.
    always_comb begin
        m_cs   = '0;
        m_addr = '0;
        m_rd   = 1'b0;
        m_wr   = 1'b0;
        m_d_in = '0;
        if (state != IDLE) begin
            m_cs = op_onehot(op);
        end
        case (state)
            WR_A: begin
                m_wr   = 1'b1;
                m_addr = U_A;
                m_d_in = op_a;
            end
            WR_B: begin
                m_wr   = 1'b1;
                m_addr = U_B;
                m_d_in = op_b;
            end
            INIT: begin
                m_wr   = 1'b1;
                m_addr = U_INIT;
                m_d_in = 16'd1;
            end
            INIT_CLR: begin
                m_wr   = 1'b1;
                m_addr = U_INIT;
            end
            POLL: begin
                m_rd   = 1'b1;
                m_addr = U_DONE;
            end
            RD_RES: begin
                m_rd   = 1'b1;
                m_addr = U_RES;
            end
            default: ;
        endcase
    end

    // Operand latches and registered CPU read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a      <= '0;
            op_b      <= '0;
            bus.d_out <= '0;
        end else begin
            if (cpu_wr && !busy) begin
                if (bus.addr == A) op_a <= bus.d_in[15:0];
                if (bus.addr == B) op_b <= bus.d_in[15:0];
            end
            if (cpu_rd) begin
                case (bus.addr)
                    RESULT:  bus.d_out <= res_q;
                    STATUS:  bus.d_out <= {29'd0, error, done, busy};
                    default: bus.d_out <= '0;
                endcase
            end
        end
    end

    // Job sequencer: one state per cycle, done/error sticky until
    // the next accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op    <= OP_MULT;
            res_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_wr && bus.addr == CTRL && bus.d_in[2]) begin
                        if (bus.d_in[1:0] != 2'd3) begin
                            op    <= op_t'(bus.d_in[1:0]);
                            done  <= 1'b0;
                            error <= 1'b0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= WR_A;
                        end else begin
                            done  <= 1'b1;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                WR_A:     state <= (op == OP_SQRT) ? INIT : WR_B;
                WR_B:     state <= INIT;
                INIT:     state <= INIT_CLR;
                INIT_CLR: state <= POLL;
                POLL:     state <= CHECK;
                CHECK: begin
                    if (sel_dout[0]) begin
                        state <= RD_RES;
                    end else if (cnt == CNT_MAX) begin
                        res_q <= '1;
                        error <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= POLL;
                    end
                end
                RD_RES:   state <= CAPT;
                CAPT: begin
                    res_q <= sel_dout;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: math-unit models with
// programmable done latency, queued expectations, negedge monitor.
module tb_calc_sequencer;
    import calc_seq_pkg::*;

    localparam int TMO = 16;

    typedef struct {
        int         len;
        int         polls;
        logic [2:0] cs;
    } job_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  m_cs;
    logic [4:0]  m_addr;
    logic        m_rd;
    logic        m_wr;
    logic [15:0] m_d_in;
    logic [31:0] mult_dout;
    logic [31:0] div_dout;
    logic [31:0] sqrt_dout;

    calc_sequencer_if bus();

    calc_sequencer #(
        .TIMEOUT_CYCLES(TMO),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .m_cs(m_cs),
        .m_addr(m_addr),
        .m_rd(m_rd),
        .m_wr(m_wr),
        .m_d_in(m_d_in),
        .mult_dout(mult_dout),
        .div_dout(div_dout),
        .sqrt_dout(sqrt_dout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    // ---------------- math unit models ----------------
    int          lat   [3] = '{0, 0, 0};
    bit          never [3] = '{0, 0, 0};
    int          left  [3] = '{0, 0, 0};
    logic [15:0] ua    [3] = '{16'd0, 16'd0, 16'd0};
    logic [15:0] ub    [3] = '{16'd0, 16'd0, 16'd0};
    logic [31:0] ures  [3] = '{32'd0, 32'd0, 32'd0};
    logic [31:0] udout [3] = '{32'd0, 32'd0, 32'd0};

    assign mult_dout = udout[0];
    assign div_dout  = udout[1];
    assign sqrt_dout = udout[2];

    function automatic logic [31:0] isqrt(logic [31:0] v);
        logic [31:0] r = 32'd0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    always @(posedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (m_cs[u] && m_wr) begin
                if (m_addr == 5'h04) ua[u] = m_d_in;
                else if (m_addr == 5'h08) ub[u] = m_d_in;
                else if (m_addr == 5'h0C && m_d_in == 16'd1) begin
                    if (u == 0)
                        ures[u] = 32'(ua[u]) * 32'(ub[u]);
                    else if (u == 1)
                        ures[u] = (ub[u] == 16'd0) ? 32'hFFFFFFFF
                                                   : 32'(ua[u] / ub[u]);
                    else
                        ures[u] = isqrt(32'(ua[u]));
                    left[u] = lat[u];
                end
            end
            if (m_cs[u] && m_rd) begin
                if (m_addr == 5'h14) begin
                    if (!never[u] && left[u] == 0) begin
                        udout[u] <= 32'h1;
                    end else begin
                        udout[u] <= 32'h0;
                        if (left[u] > 0) left[u] = left[u] - 1;
                    end
                end else if (m_addr == 5'h10) begin
                    udout[u] <= ures[u];
                end else begin
                    udout[u] <= 32'hDEADBEEF;
                end
            end
        end
    end

    // ---------------- scoreboard + monitor ----------------
    logic [31:0] exp_rd  [$];
    logic [23:0] exp_wr  [$];
    job_t        exp_job [$];

    bit   rd_pend = 0;
    bit   in_job  = 0;
    bit   aborted = 0;
    int   jlen    = 0;
    int   jpolls  = 0;
    logic [2:0] jcs = 3'd0;
    job_t jq;

    always @(negedge clk) begin
        if (rd_pend) begin
            chk("rd_queue", 32'(exp_rd.size() != 0), 32'd1);
            if (exp_rd.size() != 0)
                chk("cpu_read", bus.d_out, exp_rd.pop_front());
        end
        rd_pend = bus.cs && bus.rd && !reset;

        if (m_wr) begin
            chk("wr_queue", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0)
                chk("m_write", 32'({m_cs, m_addr, m_d_in}),
                    32'(exp_wr.pop_front()));
        end
        if (m_rd || m_wr)
            chk("rd_wr_excl", 32'(m_rd && m_wr), 32'd0);

        if (m_cs != 3'd0) begin
            if (!in_job) begin
                in_job = 1;
                jlen   = 0;
                jpolls = 0;
                jcs    = m_cs;
            end
            jlen++;
            if (m_rd && m_addr == 5'h14) jpolls++;
            chk("m_cs_stable", 32'(m_cs), 32'(jcs));
            if (reset) aborted = 1;
        end else if (in_job) begin
            in_job = 0;
            if (aborted) begin
                aborted = 0;
            end else begin
                chk("job_queue", 32'(exp_job.size() != 0), 32'd1);
                if (exp_job.size() != 0) begin
                    jq = exp_job.pop_front();
                    chk("job_cs", 32'(jcs), 32'(jq.cs));
                    chk("job_cycles", jlen, jq.len);
                    chk("job_polls", jpolls, jq.polls);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        bus.cs   = 1'b0;
        bus.rd   = 1'b0;
        bus.wr   = 1'b0;
        bus.addr = '0;
        bus.d_in = '0;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic cpu_write(logic [4:0] a, logic [31:0] d);
        bus.cs   = 1'b1;
        bus.wr   = 1'b1;
        bus.addr = a;
        bus.d_in = d;
        tick();
    endtask

    task automatic cpu_read(logic [4:0] a, logic [31:0] req);
        bus.cs   = 1'b1;
        bus.rd   = 1'b1;
        bus.addr = a;
        exp_rd.push_back(req);
        tick();
    endtask

    task automatic run_job(int op, logic [15:0] a, logic [15:0] b,
                           int l, bit nd, bit disturb);
        logic [2:0]  cs    = 3'b001 << op;
        int          pre   = (op == 2) ? 3 : 4;
        int          polls = nd ? TMO : l + 1;
        int          len   = pre + 2 * polls + (nd ? 0 : 2);
        logic [31:0] res;
        job_t        j;
        if (nd)
            res = 32'hFFFFFFFF;
        else if (op == 0)
            res = 32'(a) * 32'(b);
        else if (op == 1)
            res = 32'(a / b);
        else
            res = 32'(int'($floor($sqrt(real'(a)))));

        cpu_write(A, {16'hABCD, a});
        cpu_write(B, {16'h1234, b});
        lat[op]   = l;
        never[op] = nd;
        exp_wr.push_back({cs, U_A, a});
        if (op != 2) exp_wr.push_back({cs, U_B, b});
        exp_wr.push_back({cs, U_INIT, 16'd1});
        exp_wr.push_back({cs, U_INIT, 16'd0});
        j.len   = len;
        j.polls = polls;
        j.cs    = cs;
        exp_job.push_back(j);

        cpu_write(CTRL, 32'(4 + op));
        if (disturb) begin
            cpu_write(A, 32'(~a));
            cpu_write(B, 32'(~b));
            cpu_write(CTRL, 32'(4 + ((op + 1) % 3)));
        end else begin
            idle(3);
        end
        cpu_read(STATUS, 32'h1);
        idle(len - 5);
        cpu_read(STATUS, 32'h1);
        cpu_read(STATUS, nd ? 32'h6 : 32'h2);
        cpu_read(RESULT, res);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    int          rop;
    logic [15:0] ra;
    logic [15:0] rb;

    initial begin
        bus.cs   = 1'b0;
        bus.rd   = 1'b0;
        bus.wr   = 1'b0;
        bus.addr = '0;
        bus.d_in = '0;
        reset    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_m_cs", 32'(m_cs), 32'd0);
        chk("rst_m_addr", 32'(m_addr), 32'd0);
        chk("rst_m_strobes", 32'({m_rd, m_wr}), 32'd0);
        chk("rst_m_d_in", 32'(m_d_in), 32'd0);
        chk("rst_d_out", bus.d_out, 32'd0);
        cpu_read(STATUS, 32'h0);
        cpu_read(RESULT, 32'h0);

        run_job(0, 16'd7, 16'd6, 2, 0, 1);

        cpu_write(CTRL, 32'h7);
        cpu_read(STATUS, 32'h6);
        cpu_read(RESULT, 32'd42);

        run_job(1, 16'd100, 16'd7, 0, 0, 0);
        run_job(2, 16'd144, 16'd0, 0, 0, 0);
        run_job(0, 16'd12, 16'd12, 0, 0, 0);
        run_job(0, 16'd3, 16'd5, 0, 1, 0);
        run_job(2, 16'd50, 16'd0, 0, 1, 1);

        cpu_write(A, 32'd11);
        cpu_write(B, 32'd13);
        lat[0]   = 5;
        never[0] = 0;
        exp_wr.push_back({3'b001, U_A, 16'd11});
        exp_wr.push_back({3'b001, U_B, 16'd13});
        exp_wr.push_back({3'b001, U_INIT, 16'd1});
        exp_wr.push_back({3'b001, U_INIT, 16'd0});
        cpu_write(CTRL, 32'h4);
        idle(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_m_cs", 32'(m_cs), 32'd0);
        chk("mid_rst_m_addr", 32'(m_addr), 32'd0);
        chk("mid_rst_m_strobes", 32'({m_rd, m_wr}), 32'd0);
        chk("mid_rst_m_d_in", 32'(m_d_in), 32'd0);
        cpu_read(STATUS, 32'h0);
        cpu_read(RESULT, 32'h0);
        run_job(0, 16'd9, 16'd9, 1, 0, 0);

        for (int i = 0; i < 12; i++) begin
            rop = int'($urandom_range(0, 2));
            ra  = 16'($urandom);
            rb  = 16'($urandom_range(1, 65535));
            run_job(rop, ra, rb, int'($urandom_range(0, 4)), 0,
                    1'($urandom_range(0, 1)));
        end

        idle(3);
        chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
        chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        chk("job_queue_drained", 32'(exp_job.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
